spi_burst_protocol: RTL and testbench
=====================================

SPI_BURST_PROTOCOL -- requirements
Module: spi_burst_protocol

Interface
REQ-001 SHALL have parameter DATA_W, default 32, SPI word width.
REQ-002 SHALL have parameter ADDR_W, default 8, register address width.
REQ-003 SHALL have parameter LEN_W, default 4, burst-length field width; DATA_W >= ADDR_W+1+LEN_W is required.
REQ-004 SHALL have parameter ADDR_INC, default 1, per-word address increment; 0 gives fixed-address (FIFO-port) bursts.
REQ-005 SHALL have ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
data_fe_in  in  DATA_W  word received in the last SPI frame
ss_pos_edge  in  1  one-cycle pulse, frame end (SS deassert)
ss_neg_edge  in  1  one-cycle pulse, frame start (SS assert)
data_fe_out  out  DATA_W  word to shift out in the next frame
address  out  ADDR_W  register address
wr_data  out  DATA_W  write data
we  out  1  write strobe
rd_req  out  1  read request
rd_ack  in  1  read data valid
rd_data  in  DATA_W  read data
busy  out  1  transaction in progress
err  out  1  sticky read-underrun flag

Function
REQ-006 SHALL decode the command word as: address = data_fe_in[ADDR_W-1:0]; rnw = data_fe_in[ADDR_W]; len = data_fe_in[ADDR_W+LEN_W:ADDR_W+1]; word count = len+1 (1..2^LEN_W).
REQ-007 SHALL implement states IDLE, RD_FETCH, RD_WAIT, WR_DATA, END; all outputs registered.
REQ-008 In IDLE, on ss_pos_edge it SHALL capture address, rnw and remaining count = len, clear err, and go to RD_FETCH with rd_req<=1 if rnw=1, else go to WR_DATA.
REQ-009 In RD_FETCH, rd_req SHALL stay high until rd_ack is sampled high; on that edge rd_req<=0, data_fe_out<=rd_data, next state RD_WAIT. rd_ack in the first rd_req cycle is legal.
REQ-010 In RD_WAIT, on ss_pos_edge: if remaining=0, data_fe_out<=0 and go to END; else remaining-1, address<=address+ADDR_INC, rd_req<=1, go to RD_FETCH.
REQ-011 In WR_DATA, on ss_pos_edge it SHALL set wr_data<=data_fe_in and we<=1 for exactly one cycle, with address unchanged during the we cycle.
REQ-012 On the edge ending the we pulse: if remaining=0, go to END; else remaining-1, address<=address+ADDR_INC, stay in WR_DATA.
REQ-013 Address arithmetic SHALL wrap modulo 2^ADDR_W (e.g. 8'hFF+1 -> 8'h00).
REQ-014 ss_pos_edge in RD_FETCH (underrun) SHALL set err<=1, rd_req<=0, data_fe_out<=0 and go to END; a pending rd_ack in that same cycle is discarded.
REQ-015 In END, on ss_neg_edge it SHALL go to IDLE; all other events in END are ignored.
REQ-016 ss_neg_edge SHALL be ignored in IDLE, RD_FETCH, RD_WAIT and WR_DATA; if ss_pos_edge and ss_neg_edge coincide, ss_pos_edge takes priority.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 data_fe_out SHALL be zero except between a read-data latch and the ss_pos_edge consuming that word.

Reset
REQ-019 rst SHALL asynchronously force state=IDLE, data_fe_out=0, address=0, wr_data=0, we=0, rd_req=0, busy=0, err=0 and remaining=0, including mid-burst.
REQ-020 After rst deasserts, the first ss_pos_edge SHALL be treated as a command word.

Verification
REQ-021 Single write, defaults: cmd 0x0000_0012 (addr 0x12, rnw 0, len 0), then data 0xDEADBEEF -> one we pulse, address=0x12, wr_data=0xDEADBEEF, END, IDLE on ss_neg_edge.
REQ-022 Read burst of 3: cmd addr 0x40, rnw 1, len 2; rd_ack after 2 cycles with data 0xA0, 0xA1, 0xA2 -> rd_req at addresses 0x40, 0x41, 0x42; data_fe_out shows each value in order, then 0.
REQ-023 Write wrap: addr 0xFE, len 2 -> we at 0xFE, 0xFF, 0x00, exactly one cycle each.
REQ-024 ADDR_INC=0, 4-word write at 0x30 -> four we pulses, all at address 0x30.
REQ-025 Underrun: read command, ss_pos_edge while rd_ack held low -> err=1, data_fe_out=0, rd_req=0; err clears on the next command.
REQ-026 rst asserted during a write burst between we pulses -> all outputs at reset values the same cycle; the next frame is decoded as a command.

Source files
------------

// File: rtl/spi_burst_protocol.sv
// -----------------------------------------------------------------------------
// spi_burst_protocol
//
// Register-access protocol layered on top of an SPI word transceiver. The first
// frame after idle carries a command word (address, read/not-write, burst
// length). Subsequent frames either deliver write data, which is strobed onto
// the register bus, or collect read data, which is fetched from the register
// bus ahead of the frame that shifts it out.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   data_fe_in   word received in the last SPI frame
//   ss_pos_edge  one-cycle pulse at frame end (SS deassert)
//   ss_neg_edge  one-cycle pulse at frame start (SS assert)
//   data_fe_out  word to shift out in the next frame (zero unless read data held)
//   address      register address
//   wr_data      register write data
//   we           one-cycle register write strobe
//   rd_req       register read request, held until rd_ack
//   rd_ack       register read data valid
//   rd_data      register read data
//   busy         transaction in progress (any state other than IDLE)
//   err          sticky read-underrun flag, cleared by the next command
// -----------------------------------------------------------------------------
module spi_burst_protocol #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int LEN_W    = 4,
   parameter int ADDR_INC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_fe_in,
   input  logic              ss_pos_edge,
   input  logic              ss_neg_edge,
   output logic [DATA_W-1:0] data_fe_out,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] wr_data,
   output logic              we,
   output logic              rd_req,
   input  logic              rd_ack,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_FETCH = 3'd1,
      RD_WAIT  = 3'd2,
      WR_DATA  = 3'd3,
      END      = 3'd4
   } state_t;

   // Address step truncated to the address width so arithmetic wraps naturally.
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(ADDR_INC);

   state_t           state_r;
   logic [LEN_W-1:0] remaining_r;

   logic [ADDR_W-1:0] cmd_addr_s;
   logic              cmd_rnw_s;
   logic [LEN_W-1:0]  cmd_len_s;

   // Command word field decode.
   assign cmd_addr_s = data_fe_in[ADDR_W-1:0];
   assign cmd_rnw_s  = data_fe_in[ADDR_W];
   assign cmd_len_s  = data_fe_in[ADDR_W+LEN_W:ADDR_W+1];

   // Protocol state machine; every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         remaining_r <= {LEN_W{1'b0}};
         data_fe_out <= {DATA_W{1'b0}};
         address     <= {ADDR_W{1'b0}};
         wr_data     <= {DATA_W{1'b0}};
         we          <= 1'b0;
         rd_req      <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               // Frame end in idle: the received word is a command.
               if (ss_pos_edge) begin
                  address     <= cmd_addr_s;
                  remaining_r <= cmd_len_s;
                  err         <= 1'b0;
                  busy        <= 1'b1;
                  if (cmd_rnw_s) begin
                     rd_req  <= 1'b1;
                     state_r <= RD_FETCH;
                  end else begin
                     state_r <= WR_DATA;
                  end
               end
            end

            RD_FETCH: begin
               // A frame ending before read data arrived is an underrun; it
               // wins over an rd_ack in the same cycle.
               if (ss_pos_edge) begin
                  err         <= 1'b1;
                  rd_req      <= 1'b0;
                  data_fe_out <= {DATA_W{1'b0}};
                  state_r     <= END;
               end else if (rd_ack) begin
                  rd_req      <= 1'b0;
                  data_fe_out <= rd_data;
                  state_r     <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               // Frame end consumed the held word; fetch the next or finish.
               if (ss_pos_edge) begin
                  data_fe_out <= {DATA_W{1'b0}};
                  if (remaining_r == {LEN_W{1'b0}}) begin
                     state_r <= END;
                  end else begin
                     remaining_r <= remaining_r - LEN_W'(1);
                     address     <= address + ADDR_STEP;
                     rd_req      <= 1'b1;
                     state_r     <= RD_FETCH;
                  end
               end
            end

            WR_DATA: begin
               // we doubles as the "strobe in flight" marker: the address
               // only advances on the edge that retires the strobe.
               if (we) begin
                  we <= 1'b0;
                  if (remaining_r == {LEN_W{1'b0}}) begin
                     state_r <= END;
                  end else begin
                     remaining_r <= remaining_r - LEN_W'(1);
                     address     <= address + ADDR_STEP;
                  end
               end else if (ss_pos_edge) begin
                  wr_data <= data_fe_in;
                  we      <= 1'b1;
               end
            end

            END: begin
               if (ss_neg_edge) begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end

            default: begin
               state_r     <= IDLE;
               remaining_r <= {LEN_W{1'b0}};
               data_fe_out <= {DATA_W{1'b0}};
               we          <= 1'b0;
               rd_req      <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_burst_protocol.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_protocol
//
// Two instances share all stimulus: u_dut with ADDR_INC=1 and u_fix with
// ADDR_INC=0. Directed frames are driven from the main process, which pushes
// the expected write strobes, read requests and shift-out words into queues.
// A monitor on the falling edge pops and compares whenever a DUT presents one
// of those events. A responder answers rd_req two cycles later with the next
// queued read word.
// -----------------------------------------------------------------------------
module tb_spi_burst_protocol;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_fe_in;
   logic        ss_pos_edge;
   logic        ss_neg_edge;
   logic        rd_ack;
   logic [31:0] rd_data;

   logic [31:0] data_fe_out, wr_data;
   logic [7:0]  address;
   logic        we, rd_req, busy, err;

   logic [31:0] f_data_fe_out, f_wr_data;
   logic [7:0]  f_address;
   logic        f_we, f_rd_req, f_busy, f_err;

   int total = 0;
   int bad   = 0;
   logic ack_en = 1'b1;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } wev_t;

   wev_t        we_q[$];
   wev_t        fwe_q[$];
   logic [7:0]  rq_q[$];
   logic [7:0]  frq_q[$];
   logic [31:0] do_q[$];
   logic [31:0] rd_q[$];

   wev_t        mon_e;
   logic        prev_rq, prev_frq;
   logic [31:0] prev_do;

   always #5 clk = ~clk;

   spi_burst_protocol #(.DATA_W(32), .ADDR_W(8), .LEN_W(4), .ADDR_INC(1)) u_dut (
      .clk(clk), .rst(rst), .data_fe_in(data_fe_in),
      .ss_pos_edge(ss_pos_edge), .ss_neg_edge(ss_neg_edge),
      .data_fe_out(data_fe_out), .address(address), .wr_data(wr_data),
      .we(we), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
      .busy(busy), .err(err)
   );

   spi_burst_protocol #(.DATA_W(32), .ADDR_W(8), .LEN_W(4), .ADDR_INC(0)) u_fix (
      .clk(clk), .rst(rst), .data_fe_in(data_fe_in),
      .ss_pos_edge(ss_pos_edge), .ss_neg_edge(ss_neg_edge),
      .data_fe_out(f_data_fe_out), .address(f_address), .wr_data(f_wr_data),
      .we(f_we), .rd_req(f_rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
      .busy(f_busy), .err(f_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: event seen with nothing expected", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_we(input logic [7:0] a, input logic [7:0] fa, input logic [31:0] d);
      we_q.push_back('{a: a, d: d});
      fwe_q.push_back('{a: fa, d: d});
   endtask

   task automatic exp_rq(input logic [7:0] a, input logic [7:0] fa);
      rq_q.push_back(a);
      frq_q.push_back(fa);
   endtask

   // One SPI frame: SS assert, some bit time, then the received word at SS deassert.
   task automatic frame(input logic [31:0] w);
      ss_neg_edge = 1'b1;
      tick();
      ss_neg_edge = 1'b0;
      repeat (6) tick();
      data_fe_in  = w;
      ss_pos_edge = 1'b1;
      tick();
      ss_pos_edge = 1'b0;
      data_fe_in  = 32'h0;
      repeat (3) tick();
   endtask

   // Register-bus read responder: ack two cycles after seeing rd_req.
   initial begin
      forever begin
         tick();
         if (ack_en && rd_req && !rst) begin
            tick();
            rd_ack  = 1'b1;
            rd_data = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
            tick();
            rd_ack  = 1'b0;
            rd_data = 32'h0;
         end
      end
   end

   // Scoreboard monitor: compare each observed event against its queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (we) begin
            if (we_q.size() == 0) unexpected("we");
            else begin
               mon_e = we_q.pop_front();
               check("we_addr", {24'h0, address}, {24'h0, mon_e.a});
               check("we_data", wr_data, mon_e.d);
            end
         end
         if (f_we) begin
            if (fwe_q.size() == 0) unexpected("fix_we");
            else begin
               mon_e = fwe_q.pop_front();
               check("fix_we_addr", {24'h0, f_address}, {24'h0, mon_e.a});
               check("fix_we_data", f_wr_data, mon_e.d);
            end
         end
         if (rd_req && !prev_rq) begin
            if (rq_q.size() == 0) unexpected("rd_req");
            else check("rd_req_addr", {24'h0, address}, {24'h0, rq_q.pop_front()});
         end
         if (f_rd_req && !prev_frq) begin
            if (frq_q.size() == 0) unexpected("fix_rd_req");
            else check("fix_rd_req_addr", {24'h0, f_address}, {24'h0, frq_q.pop_front()});
         end
         if (data_fe_out !== prev_do) begin
            if (do_q.size() == 0) unexpected("data_fe_out");
            else check("data_fe_out", data_fe_out, do_q.pop_front());
         end
      end
      prev_rq  <= rd_req;
      prev_frq <= f_rd_req;
      prev_do  <= data_fe_out;
   end

   initial begin
      rst = 1'b1;
      data_fe_in = 32'h0;
      ss_pos_edge = 1'b0;
      ss_neg_edge = 1'b0;
      rd_ack = 1'b0;
      rd_data = 32'h0;
      repeat (3) tick();
      check("rst_data_fe_out", data_fe_out, 32'h0);
      check("rst_address", {24'h0, address}, 32'h0);
      check("rst_wr_data", wr_data, 32'h0);
      check("rst_we_rd_req", {30'h0, we, rd_req}, 32'h0);
      check("rst_busy_err", {30'h0, busy, err}, 32'h0);
      rst = 1'b0;
      repeat (2) tick();

      // Single write at 0x12.
      exp_we(8'h12, 8'h12, 32'hDEADBEEF);
      frame(32'h0000_0012);
      check("wr_cmd_busy", {31'h0, busy}, 32'h1);
      frame(32'hDEADBEEF);
      check("wr_end_busy", {31'h0, busy}, 32'h1);
      ss_neg_edge = 1'b1;
      tick();
      ss_neg_edge = 1'b0;
      tick();
      check("wr_idle_busy", {31'h0, busy}, 32'h0);

      // Read burst of 3 at 0x40: cmd = 0x40 | rnw<<8 | 2<<9.
      rd_q.push_back(32'hA0);
      rd_q.push_back(32'hA1);
      rd_q.push_back(32'hA2);
      exp_rq(8'h40, 8'h40);
      exp_rq(8'h41, 8'h40);
      exp_rq(8'h42, 8'h40);
      do_q.push_back(32'hA0);
      do_q.push_back(32'h0);
      do_q.push_back(32'hA1);
      do_q.push_back(32'h0);
      do_q.push_back(32'hA2);
      do_q.push_back(32'h0);
      frame(32'h0000_0540);
      frame(32'h0);
      frame(32'h0);
      frame(32'h0);
      check("rd_end_data_fe_out", data_fe_out, 32'h0);

      // Write burst wrapping past 0xFF: cmd = 0xFE | 2<<9.
      exp_we(8'hFE, 8'hFE, 32'h1);
      exp_we(8'hFF, 8'hFE, 32'h2);
      exp_we(8'h00, 8'hFE, 32'h3);
      frame(32'h0000_04FE);
      frame(32'h1);
      frame(32'h2);
      frame(32'h3);

      // 4-word write at 0x30: incrementing vs fixed address.
      exp_we(8'h30, 8'h30, 32'h11);
      exp_we(8'h31, 8'h30, 32'h22);
      exp_we(8'h32, 8'h30, 32'h33);
      exp_we(8'h33, 8'h30, 32'h44);
      frame(32'h0000_0630);
      frame(32'h11);
      frame(32'h22);
      frame(32'h33);
      frame(32'h44);

      // Underrun: read at 0x10 with no rd_ack before the data frame ends.
      ack_en = 1'b0;
      exp_rq(8'h10, 8'h10);
      frame(32'h0000_0110);
      check("ur_rd_req_held", {31'h0, rd_req}, 32'h1);
      frame(32'h0);
      check("ur_err", {31'h0, err}, 32'h1);
      check("ur_fix_err", {31'h0, f_err}, 32'h1);
      check("ur_rd_req", {31'h0, rd_req}, 32'h0);
      check("ur_data_fe_out", data_fe_out, 32'h0);
      ack_en = 1'b1;
      exp_we(8'h08, 8'h08, 32'h99);
      frame(32'h0000_0008);
      check("ur_err_cleared", {31'h0, err}, 32'h0);
      frame(32'h99);

      // Reset between strobes of a write burst at 0x20 (len 3).
      exp_we(8'h20, 8'h20, 32'h55);
      frame(32'h0000_0620);
      frame(32'h55);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_address", {24'h0, address}, 32'h0);
      check("mid_rst_wr_data", wr_data, 32'h0);
      check("mid_rst_busy", {30'h0, busy, f_busy}, 32'h0);
      check("mid_rst_we_rd_req_err", {29'h0, we, rd_req, err}, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      exp_we(8'h05, 8'h05, 32'h77);
      frame(32'h0000_0005);
      frame(32'h77);
      repeat (5) tick();

      check("left_we", we_q.size(), 32'h0);
      check("left_fix_we", fwe_q.size(), 32'h0);
      check("left_rd_req", rq_q.size() + frq_q.size(), 32'h0);
      check("left_data_fe_out", do_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
